apb_slave_regs: RTL and testbench
=================================

Name: apb_slave_regs

Overview:
APB completer (slave) that answers the APB master's PSEL/PENABLE/PWRITE transfers.
- Holds a bank of NUM_REGS 32-bit read/write registers.
- Inserts a programmable number of wait states through PREADY.
- Flags illegal accesses on PSLVERR.
- Sits on the peripheral side of the APB bus; register contents are exported flat to surrounding logic.

Parameters:
NUM_REGS, 8, number of 32-bit registers (1..256)
ADDR_W, 32, width of PADDR
WAIT_STATES, 0, extra wait cycles in ACCESS phase before PREADY (0..15)
RESET_VAL, 32'h0000_0000, reset value of every register

Ports:
PCLK  in  1  clock, all logic on posedge
PRESET  in  1  synchronous, active-high reset
PSEL  in  1  slave select from master
PENABLE  in  1  ACCESS-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid while PREADY=1
PREADY  out  1  transfer-complete strobe
PSLVERR  out  1  error, valid only while PREADY=1
regs_flat  out  NUM_REGS*32  register contents, reg i at bits [32*i+31:32*i]

Behaviour:
- Reset (PRESET=1 at posedge):
  - All registers = RESET_VAL.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - State = IDLE, wait counter = 0.
  - Reset takes priority over everything, including a transfer in progress; an aborted write does not commit.
- State machine: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - On an edge sampling PSEL=1 & PENABLE=0 (SETUP), latch PADDR, PWRITE, PWDATA.
  - Load counter = WAIT_STATES, go to ACCESS.
  - Any other input combination: stay in IDLE.
- ACCESS, on each edge with PSEL=1 & PENABLE=1:
  - If counter != 0: decrement and stay.
  - If counter = 0: set PREADY=1, drive PSLVERR/PRDATA, commit the write, go to RESP.
- Latency: PREADY is high in the (WAIT_STATES+2)th cycle after the SETUP edge. For WAIT_STATES=0: SETUP cycle, one ACCESS cycle with PREADY=0, then the PREADY cycle.
- RESP: PREADY=1 for exactly one cycle. Next edge: PREADY=0, PSLVERR=0, go to IDLE. PRDATA holds its last value.
- Back-to-back transfers: after RESP the slave is in IDLE, so a SETUP on the following cycle is accepted with no bubble.
- Decode:
  - idx = PADDR[ADDR_W-1:2].
  - Error if idx >= NUM_REGS or PADDR[1:0] != 0.
  - On error: PSLVERR=1 with PREADY, no register written, PRDATA=32'h0.
- Read: PRDATA = reg[idx].
- Write: reg[idx] = latched PWDATA at the RESP-entry edge; regs_flat shows the new value during the RESP cycle.
- Protocol violations:
  - PSEL drops in ACCESS: abort to IDLE, no write, PREADY stays 0.
  - PENABLE=0 while in ACCESS with PSEL=1: treated as a new SETUP; re-latch inputs and reload the counter.
- PREADY never asserts in IDLE.

Optional Feature:
APB_SLAVE_PSTRB_EN
- Defined:
  - Adds input PSTRB [3:0], latched at SETUP.
  - A write updates only the byte lanes whose strobe bit is 1.
  - Reads ignore PSTRB.
  - PSTRB=4'b0000 on a write is legal, completes normally, and changes nothing.
- Undefined: no PSTRB port; every write updates all 32 bits.

Decomposition:
- Package apb_pkg holds:
  - state enum apb_slv_state_t {IDLE, ACCESS, RESP};
  - APB_DATA_W = 32;
  - byte-offset width constant APB_BYTE_OFF_W = 2.
- One natural sub-module: apb_reg_bank. It holds the registers, write enable, byte strobes and read mux, and is reset by PRESET. The FSM, wait counter and decode stay in the top level.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF to PADDR=0x04, then read 0x04 -> PREADY high exactly 2 cycles after each SETUP edge; PRDATA=32'hDEAD_BEEF; PSLVERR=0; regs_flat[63:32]=32'hDEAD_BEEF.
- WAIT_STATES=3: read PADDR=0x00 after reset -> PREADY low for 4 ACCESS cycles, high on the 5th; PRDATA=RESET_VAL.
- Illegal addresses: write to PADDR=0x20 (idx 8, NUM_REGS=8) and to 0x02 (misaligned) -> PSLVERR=1 with PREADY; all registers unchanged.
- Reset mid-transfer: PRESET=1 in ACCESS of a write of 32'h1234_5678 to 0x08 -> PREADY=0 next cycle; reg2 = RESET_VAL; state IDLE.
- PSEL abort: deassert PSEL in ACCESS of a write to 0x0C -> no PREADY pulse; reg3 unchanged. A following normal read of 0x0C completes correctly.
- With APB_SLAVE_PSTRB_EN: reg1=32'hFFFF_FFFF, write 32'h0000_0000 with PSTRB=4'b0101 -> reg1=32'hFF00_FF00.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } apb_slv_state_t;

  localparam int APB_DATA_W     = 32;
  localparam int APB_BYTE_OFF_W = 2;
  localparam int APB_STRB_W     = APB_DATA_W / 8;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: byte-strobed write port, indexed read mux
// and a flat export of every register.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS  = 8,
  parameter int                    IDX_W     = 3,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               idx,
  input  logic [APB_DATA_W-1:0]          wdata,
  input  logic [APB_STRB_W-1:0]          wstrb,
  output logic [APB_DATA_W-1:0]          rdata,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_flat
);

  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
  logic [APB_DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (int'(idx) == i)) begin
        for (int b = 0; b < APB_STRB_W; b++) begin
          if (wstrb[b]) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index may exceed NUM_REGS-1 when NUM_REGS is not a power of two; read 0 then.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) rdata = regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[APB_DATA_W*g +: APB_DATA_W] = regs_q[g];
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with programmable wait states, address-error reporting and a flat register export.
// Define APB_SLAVE_PSTRB_EN to add the PSTRB byte-lane write strobe port.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 8,
  parameter int                    ADDR_W      = 32,
  parameter int                    WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_W-1:0]              PADDR,
  input  logic [APB_DATA_W-1:0]          PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [APB_STRB_W-1:0]          PSTRB,
`endif
  output logic [APB_DATA_W-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_flat
);

  localparam int                          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]                  WS_LOAD    = 4'(WAIT_STATES);
  localparam logic [ADDR_W-APB_BYTE_OFF_W-1:0] NUM_REGS_A = (ADDR_W-APB_BYTE_OFF_W)'(NUM_REGS);

  apb_slv_state_t          state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    write_q, write_d;
  logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
  logic [APB_STRB_W-1:0]   strb_q, strb_d;
  logic [APB_DATA_W-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;

  logic [APB_STRB_W-1:0]   strb_in;
  logic [APB_DATA_W-1:0]   bank_rdata;
  logic                    wr_en;
  logic                    acc_err;
  logic                    setup;

`ifdef APB_SLAVE_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  assign acc_err = (addr_q[ADDR_W-1:APB_BYTE_OFF_W] >= NUM_REGS_A) ||
                   (addr_q[APB_BYTE_OFF_W-1:0] != '0);

  // A SETUP seen while already in ACCESS restarts the transfer with fresh inputs.
  assign setup = PSEL && !PENABLE && ((state_q == IDLE) || (state_q == ACCESS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en     = 1'b0;

    if (setup) begin
      addr_d  = PADDR;
      write_d = PWRITE;
      wdata_d = PWDATA;
      strb_d  = strb_in;
      cnt_d   = WS_LOAD;
      state_d = ACCESS;
    end else begin
      case (state_q)
        ACCESS: begin
          if (!PSEL) begin
            state_d = IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = acc_err ? '0 : bank_rdata;
            wr_en     = write_q && !acc_err;
            state_d   = RESP;
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk       (PCLK),
    .rst       (PRESET),
    .wr_en     (wr_en),
    .idx       (addr_q[APB_BYTE_OFF_W +: IDX_W]),
    .wdata     (wdata_q),
    .wstrb     (strb_q),
    .rdata     (bank_rdata),
    .regs_flat (regs_flat)
  );

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: one instance with no wait states, one with three,
// driven through table vectors plus hand-written protocol corner cases.
module tb_apb_slave_regs;

  localparam int          NREG = 8;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int          WS0  = 0;
  localparam int          WS1  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              preset  [2];
  logic              psel    [2];
  logic              penable [2];
  logic              pwrite  [2];
  logic [31:0]       paddr   [2];
  logic [31:0]       pwdata  [2];
  logic [3:0]        pstrb   [2];
  logic [31:0]       prdata  [2];
  logic              pready  [2];
  logic              pslverr [2];
  logic [NREG*32-1:0] rflat  [2];

  apb_slave_regs #(.NUM_REGS(NREG), .ADDR_W(32), .WAIT_STATES(WS0), .RESET_VAL(RV)) dut0 (
    .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .regs_flat(rflat[0])
  );

  apb_slave_regs #(.NUM_REGS(NREG), .ADDR_W(32), .WAIT_STATES(WS1), .RESET_VAL(RV)) dut1 (
    .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .regs_flat(rflat[1])
  );

  typedef struct {
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  sb_t         sbq[$];
  logic [31:0] mdl [2][NREG];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int d, input int i);
    return rflat[d][32*i +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    logic [3:0]  m;
    r = old;
    m = s;
`ifndef APB_SLAVE_PSTRB_EN
    m = 4'hF;
`endif
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk_bank(input int d);
    for (int i = 0; i < NREG; i++) chk("bank", reg_of(d, i), mdl[d][i]);
  endtask

  // Called at a negedge; returns one cycle after the PREADY cycle, ready for the next SETUP.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit exp_err, input logic [31:0] exp_rd);
    sb_t e;
    sb_t got;
    int  k;
    int  idx;
    e.err    = exp_err;
    e.rd     = exp_rd;
    e.chk_rd = !wr || exp_err;
    sbq.push_back(e);
    idx = int'(addr >> 2);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(negedge clk);
    penable[d] = 1'b1;
    k = 1;
    while (!pready[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'((d == 0 ? WS0 : WS1) + 2));
    got = sbq.pop_front();
    chk("pready", 32'(pready[d]), 32'd1);
    chk("pslverr", 32'(pslverr[d]), 32'(got.err));
    if (got.chk_rd) chk("prdata", prdata[d], got.rd);
    if (!exp_err) begin
      if (wr) mdl[d][idx] = merge(mdl[d][idx], wdata, strb);
      chk("regs_flat_resp", reg_of(d, idx), mdl[d][idx]);
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge clk);
    chk("pready_one_cycle", 32'(pready[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[10];
    int   k;
    bit   seen;

    tv[0] = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tv[1] = '{1'b0, 32'h04, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tv[2] = '{1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b1, 32'h0};
    tv[3] = '{1'b1, 32'h02, 32'h2222_2222, 4'hF, 1'b1, 32'h0};
    tv[4] = '{1'b0, 32'h01, 32'h0,         4'hF, 1'b1, 32'h0};
    tv[5] = '{1'b0, 32'h20, 32'h0,         4'hF, 1'b1, 32'h0};
    tv[6] = '{1'b0, 32'h00, 32'h0,         4'hF, 1'b0, RV};
    tv[7] = '{1'b1, 32'h1C, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0};
    tv[8] = '{1'b0, 32'h1C, 32'h0,         4'hF, 1'b0, 32'hA5A5_0001};
    tv[9] = '{1'b0, 32'h04, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};

    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = 4'hF;
      for (int i = 0; i < NREG; i++) mdl[d][i] = RV;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_prdata", prdata[d], 32'h0);
      chk("rst_pready", 32'(pready[d]), 32'd0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
      chk_bank(d);
      preset[d] = 1'b0;
    end
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      xfer(0, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].strb, tv[i].exp_err, tv[i].exp_rd);
    chk_bank(0);

    // Wait-state instance: read after reset, then a write/read pair.
    xfer(1, 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, RV);
    xfer(1, 1'b1, 32'h18, 32'hCAFE_0042, 4'hF, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h18, 32'h0, 4'hF, 1'b0, 32'hCAFE_0042);

    // Reset during ACCESS of a write: nothing commits, no PREADY.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h08; pwdata[0] = 32'h1234_5678;
    @(negedge clk);
    penable[0] = 1'b1; preset[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREG; i++) mdl[0][i] = RV;
    chk("rst_mid_pready", 32'(pready[0]), 32'd0);
    chk("rst_mid_prdata", prdata[0], 32'h0);
    chk("rst_mid_reg2", reg_of(0, 2), RV);
    chk_bank(0);
    preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, RV);

    // PSEL dropped during ACCESS aborts without a response or a write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h5555_5555;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[1]) seen = 1'b1;
    end
    chk("abort_no_pready", 32'(seen), 32'd0);
    chk("abort_reg3", reg_of(1, 3), RV);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0, RV);

    // SETUP while in ACCESS restarts the transfer with the new address and counter.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'hAAAA_0000;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    penable[1] = 1'b0; paddr[1] = 32'h14; pwdata[1] = 32'hBBBB_0000;
    @(negedge clk);
    penable[1] = 1'b1;
    k = 1;
    while (!pready[1] && k < 40) begin
      @(negedge clk);
      k++;
    end
    mdl[1][5] = 32'hBBBB_0000;
    chk("resetup_latency", 32'(k), 32'(WS1 + 2));
    chk("resetup_pslverr", 32'(pslverr[1]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    chk_bank(1);

`ifdef APB_SLAVE_PSTRB_EN
    xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0);
    xfer(0, 1'b1, 32'h04, 32'h0000_0000, 4'b0101, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h04, 32'h0,         4'b0000, 1'b0, 32'hFF00_FF00);
    xfer(0, 1'b1, 32'h04, 32'h1234_5678, 4'b0000, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h04, 32'h0,         4'hF,    1'b0, 32'hFF00_FF00);
    chk_bank(0);
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
